// File: rtl/regf_mp_pkg.sv
// Shared types and default sizes for the multi-port register file.
package regf_mp_pkg;

  localparam int XLEN_D = 32;
  localparam int NREG_D = 32;

  // CLEAR: zeroing registers after reset; READY: normal operation.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } regf_state_e;

endpackage

// File: rtl/regf_scoreboard.sv
// Busy-bit scoreboard: one bit per register with set, clear and clear-all,
// plus NRD registered lookups. Bit 0 is never busy.
// Optional macro REGF_MP_BYPASS_EN: a lookup whose address matches the
// register being cleared by a write this cycle returns the post-edge bit.
module regf_scoreboard #(
  parameter  int NREG = 32,
  parameter  int NRD  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              i_clr_all,
  input  logic              i_set_en,
  input  logic [AW-1:0]     i_set_addr,
  input  logic              i_clr_en,
  input  logic [AW-1:0]     i_clr_addr,
  input  logic              i_lk_en,
  input  logic              i_lk_zero,
  input  logic [NRD*AW-1:0] i_lk_addr,
  output logic [NRD-1:0]    o_lk_busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic [NRD-1:0]  w_lk_val;
  logic [AW-1:0]   w_lk_addr [NRD];

  // Next busy vector: set takes priority over a write's clear on the same bit.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_en) w_busy_nxt[i_clr_addr] = 1'b0;
    if (i_set_en) w_busy_nxt[i_set_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Per-port lookup value, optionally forwarding the post-edge bit on a write hit.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      w_lk_addr[i] = i_lk_addr[i*AW +: AW];
      w_lk_val[i]  = r_busy[w_lk_addr[i]];
`ifdef REGF_MP_BYPASS_EN
      if (i_clr_en && (i_clr_addr == w_lk_addr[i])) w_lk_val[i] = w_busy_nxt[w_lk_addr[i]];
`endif
    end
  end

  // Busy storage with synchronous clear-all.
  always_ff @(posedge clk) begin
    if (i_clr_all) r_busy <= '0;
    else           r_busy <= w_busy_nxt;
  end

  // Registered lookups: forced to zero, captured on enable, otherwise held.
  always_ff @(posedge clk) begin
    if (i_lk_zero)    o_lk_busy <= '0;
    else if (i_lk_en) o_lk_busy <= w_lk_val;
  end

endmodule

// File: rtl/regf_mp.sv
// Multi-port register file with post-reset clear sequence and busy scoreboard.
// Optional macro REGF_MP_BYPASS_EN: a same-cycle write to a nonzero address
// is forwarded to any read port addressing it.
// Read/write handshake: there is no back-pressure; rd_en captures all ports
// in the cycle it is high, results appear one cycle later and are held while
// rd_en is low. Writes and busy-sets are accepted only while ready is high.
module regf_mp
  import regf_mp_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NREG = NREG_D,
  parameter int NRD  = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  output logic                      ready,
  input  logic                      rd_en,
  input  logic [NRD*$clog2(NREG)-1:0] rd_addr,
  output logic [NRD*XLEN-1:0]       rd_data,
  output logic [NRD-1:0]            rd_busy,
  input  logic                      w_enable,
  input  logic [$clog2(NREG)-1:0]   w_addr,
  input  logic [XLEN-1:0]           w_data,
  input  logic                      bs_enable,
  input  logic [$clog2(NREG)-1:0]   bs_addr,
  output regf_state_e               o_dbg_state
);

  localparam int            AW   = $clog2(NREG);
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  regf_state_e       r_state;
  logic [AW-1:0]     r_cnt;
  logic              r_ready;
  logic [XLEN-1:0]   r_regs [NREG];
  logic [NRD*XLEN-1:0] r_rd_data;

  logic              w_we;
  logic              w_bs;
  logic              w_lk_zero;
  logic [AW-1:0]     w_rd_addr [NRD];
  logic [XLEN-1:0]   w_rd_val  [NRD];

  assign w_we      = (r_state == READY) && w_enable  && (w_addr  != '0);
  assign w_bs      = (r_state == READY) && bs_enable && (bs_addr != '0);
  assign w_lk_zero = !rstn || (r_state == CLEAR);

  assign ready       = r_ready;
  assign rd_data     = r_rd_data;
  assign o_dbg_state = r_state;

  // Clear-sequence FSM: walks the counter over every register, then goes READY.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          if (r_cnt == LAST) begin
            r_state <= READY;
            r_ready <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        READY: r_ready <= 1'b1;
      endcase
    end
  end

  // Register storage: zeroed one entry per cycle in CLEAR, written in READY.
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (r_state == CLEAR) r_regs[r_cnt]  <= '0;
      else if (w_we)        r_regs[w_addr] <= w_data;
    end
  end

  // Read mux per port; register 0 is hard-wired to zero.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      w_rd_addr[i] = rd_addr[i*AW +: AW];
      w_rd_val[i]  = (w_rd_addr[i] == '0) ? '0 : r_regs[w_rd_addr[i]];
`ifdef REGF_MP_BYPASS_EN
      if (w_we && (w_addr == w_rd_addr[i])) w_rd_val[i] = w_data;
`endif
    end
  end

  // Registered read data: zero during reset/CLEAR, captured on rd_en, else held.
  always_ff @(posedge clk) begin
    if (w_lk_zero) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      for (int i = 0; i < NRD; i++) r_rd_data[i*XLEN +: XLEN] <= w_rd_val[i];
    end
  end

  regf_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD)
  ) u_sb (
    .clk        (clk),
    .i_clr_all  (!rstn),
    .i_set_en   (w_bs),
    .i_set_addr (bs_addr),
    .i_clr_en   (w_we),
    .i_clr_addr (w_addr),
    .i_lk_en    (rd_en),
    .i_lk_zero  (w_lk_zero),
    .i_lk_addr  (rd_addr),
    .o_lk_busy  (rd_busy)
  );

endmodule

// File: tb/tb_regf_mp.sv
// Self-checking bench for regf_mp (default build, or with REGF_MP_BYPASS_EN).
module tb_regf_mp;
  import regf_mp_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic                rd_en     = 1'b0;
  logic [NRD*AW-1:0]   rd_addr   = '0;
  logic                w_enable  = 1'b0;
  logic [AW-1:0]       w_addr    = '0;
  logic [XLEN-1:0]     w_data    = '0;
  logic                bs_enable = 1'b0;
  logic [AW-1:0]       bs_addr   = '0;
  logic                ready;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  regf_state_e         o_dbg_state;

  regf_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .ready       (ready),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .w_enable    (w_enable),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .bs_enable   (bs_enable),
    .bs_addr     (bs_addr),
    .o_dbg_state (o_dbg_state)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                       input logic be, input logic [AW-1:0] ba,
                       input logic re, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    w_enable  = we;
    w_addr    = wa;
    w_data    = wd;
    bs_enable = be;
    bs_addr   = ba;
    rd_en     = re;
    rd_addr   = {a1, a0};
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until ready rises (bounded); returns the number of edges taken.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      step();
      n++;
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_regs [NREG];
  logic            m_busy [NREG];
  logic [XLEN-1:0] m_rd   [NRD];
  logic            m_rb   [NRD];

  function automatic void model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    for (int i = 0; i < NRD; i++) begin
      m_rd[i] = '0;
      m_rb[i] = 1'b0;
    end
  endfunction

  // One READY-state cycle using the currently driven inputs.
  function automatic void model_cycle();
    logic [AW-1:0] a;
    if (rd_en) begin
      for (int i = 0; i < NRD; i++) begin
        a = rd_addr[i*AW +: AW];
        m_rd[i] = (a == 0) ? '0 : m_regs[a];
        m_rb[i] = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGF_MP_BYPASS_EN
        if (w_enable && w_addr != 0 && w_addr == a) begin
          m_rd[i] = w_data;
          m_rb[i] = bs_enable && (bs_addr == a);
        end
`endif
      end
    end
    if (w_enable && w_addr != 0) begin
      m_regs[w_addr] = w_data;
      m_busy[w_addr] = 1'b0;
    end
    if (bs_enable && bs_addr != 0) m_busy[bs_addr] = 1'b1;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            be;
    logic [AW-1:0]   ba;
    logic            re;
    logic [AW-1:0]   a0;
    logic [AW-1:0]   a1;
    logic [XLEN-1:0] d0;
    logic [XLEN-1:0] d1;
    logic            b0;
    logic            b1;
  } vec_t;

  vec_t vt [12];

  // ---------------- scoreboard queue ----------------
  logic [XLEN-1:0] exp_q [$];

  initial begin
    int n;
    logic [XLEN-1:0] e;
    logic [XLEN-1:0] byp_exp;

    vt[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b1, 5'd1, 5'd2, 32'h0,        32'h0,        1'b0, 1'b0};
    vt[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 1'b1, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    vt[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0};
    vt[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b1, 5'd7, 5'd5, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd7, 5'd0, 32'h0,        32'h0,        1'b1, 1'b0};
    vt[6]  = '{1'b1, 5'd7, 32'h55,       1'b0, 5'd0, 1'b0, 5'd7, 5'd7, 32'h0,        32'h0,        1'b1, 1'b0};
    vt[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd7, 5'd7, 32'h55,       32'h55,       1'b0, 1'b0};
    vt[8]  = '{1'b1, 5'd9, 32'h99,       1'b1, 5'd9, 1'b0, 5'd0, 5'd0, 32'h55,       32'h55,       1'b0, 1'b0};
    vt[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd9, 5'd7, 32'h99,       32'h55,       1'b1, 1'b0};
    vt[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 1'b1, 5'd0, 5'd9, 32'h0,        32'h99,       1'b0, 1'b1};
    vt[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0};

    // Reset state
    idle();
    rstn = 1'b0;
    step();
    step();
    chk("reset_ready", {31'b0, ready}, 32'h0);
    chk("reset_rd0", rd_data[31:0], 32'h0);
    chk("reset_rd1", rd_data[63:32], 32'h0);
    chk("reset_busy", {30'b0, rd_busy}, 32'h0);
    chk("reset_state", {31'b0, o_dbg_state}, {31'b0, CLEAR});

    // One-cycle reset then release: ready rises after exactly NREG edges
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("clear_ready_low", {31'b0, ready}, 32'h0);
    wait_ready(n);
    chk("clear_len", n, NREG);
    chk("ready_high", {31'b0, ready}, 32'h1);

    // Every register reads zero after the clear
    for (int a = 0; a < NREG; a += 2) begin
      drive(1'b0, '0, '0, 1'b0, '0, 1'b1, AW'(a), AW'(a + 1));
      step();
      chk($sformatf("cleared_r%0d", a), rd_data[31:0], 32'h0);
      chk($sformatf("cleared_r%0d", a + 1), rd_data[63:32], 32'h0);
    end

    // Table-driven vectors
    for (int v = 0; v < 12; v++) begin
      drive(vt[v].we, vt[v].wa, vt[v].wd, vt[v].be, vt[v].ba, vt[v].re, vt[v].a0, vt[v].a1);
      step();
      chk($sformatf("vec%0d_d0", v), rd_data[31:0], vt[v].d0);
      chk($sformatf("vec%0d_d1", v), rd_data[63:32], vt[v].d1);
      chk($sformatf("vec%0d_b0", v), {31'b0, rd_busy[0]}, {31'b0, vt[v].b0});
      chk($sformatf("vec%0d_b1", v), {31'b0, rd_busy[1]}, {31'b0, vt[v].b1});
    end

    // Same-cycle write and read of reg 3
`ifdef REGF_MP_BYPASS_EN
    byp_exp = 32'hA5A5A5A5;
`else
    byp_exp = 32'h0;
`endif
    drive(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, '0, 1'b1, 5'd3, 5'd3);
    step();
    chk("bypass_d0", rd_data[31:0], byp_exp);
    chk("bypass_d1", rd_data[63:32], byp_exp);
    chk("bypass_busy", {30'b0, rd_busy}, 32'h0);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd3, 5'd3);
    step();
    chk("after_bypass_d0", rd_data[31:0], 32'hA5A5A5A5);

    // Reset in mid-CLEAR restarts the sequence; writes/sets during CLEAR are ignored
    drive(1'b0, '0, '0, 1'b1, 5'd4, 1'b0, '0, '0);
    step();
    idle();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    for (int c = 0; c < 10; c++) step();
    chk("midclear_ready", {31'b0, ready}, 32'h0);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    drive(1'b1, 5'd6, 32'hCAFEF00D, 1'b1, 5'd6, 1'b0, '0, '0);
    for (int c = 0; c < 20; c++) step();
    idle();
    wait_ready(n);
    chk("restart_len", n + 20, NREG);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd4, 5'd6);
    step();
    chk("restart_r4", rd_data[31:0], 32'h0);
    chk("restart_r6", rd_data[63:32], 32'h0);
    chk("restart_busy", {30'b0, rd_busy}, 32'h0);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd5, 5'd7);
    step();
    chk("restart_r5", rd_data[31:0], 32'h0);
    chk("restart_r7", rd_data[63:32], 32'h0);

    // Randomized traffic against the reference model
    idle();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    wait_ready(n);
    chk("rand_clear_len", n, NREG);
    model_reset();
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), rnd_addr(), $urandom,
            1'($urandom_range(0, 2) == 0), rnd_addr(),
            1'($urandom_range(0, 4) != 0), rnd_addr(), rnd_addr());
      model_cycle();
      step();
      exp_q.push_back(m_rd[0]);
      exp_q.push_back(m_rd[1]);
      exp_q.push_back({30'b0, m_rb[1], m_rb[0]});
      e = exp_q.pop_front();
      chk($sformatf("rand%0d_d0", c), rd_data[31:0], e);
      e = exp_q.pop_front();
      chk($sformatf("rand%0d_d1", c), rd_data[63:32], e);
      e = exp_q.pop_front();
      chk($sformatf("rand%0d_busy", c), {30'b0, rd_busy}, e);
    end
    idle();

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
